// File: rtl/bram_fifo_cfg_pkg.sv
// Shared datapath definitions: buffer mode encodings, default accumulator-path
// sizes and the address-width helper.
package bram_fifo_cfg_pkg;

    localparam logic MODE_FIFO  = 1'b0;
    localparam logic MODE_DELAY = 1'b1;

    localparam int ACC_DATA_WIDTH = 25;
    localparam int ACC_MAX_DEPTH  = 1024;

    // Number of bits needed to represent the value 'depth'.
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        while (d > 0) begin
            r++;
            d = d >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_fifo_cfg_bram.sv
// Block RAM with a write port (A) and a read port (B); a same-address
// write and read in one cycle returns the word stored before the write.
module BRAM_singlePort_readFirst #(
    parameter int    RAM_WIDTH       = 25,
    parameter int    RAM_DEPTH       = 1024,
    parameter int    AW              = 10,
    parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
    input  logic                 clk,
    input  logic [AW-1:0]        addra,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 ena,
    input  logic                 wea,
    input  logic                 enb,
    input  logic                 rstb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_reg;

    always_ff @(posedge clk) begin
        if (ena && wea)
            ram[addra] <= dina;
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            // Single registered stage; regceb acts as its clock enable.
            always_ff @(posedge clk) begin
                if (rstb)
                    ram_data_reg <= '0;
                else if (enb && regceb)
                    ram_data_reg <= ram[addrb];
            end
            assign doutb = ram_data_reg;
        end else begin : g_high_performance
            logic [RAM_WIDTH-1:0] doutb_reg;
            always_ff @(posedge clk) begin
                if (enb)
                    ram_data_reg <= ram[addrb];
            end
            always_ff @(posedge clk) begin
                if (rstb)
                    doutb_reg <= '0;
                else if (regceb)
                    doutb_reg <= ram_data_reg;
            end
            assign doutb = doutb_reg;
        end
    endgenerate

endmodule

// File: rtl/bram_fifo_cfg.sv
// Runtime-configurable BRAM buffer: guarded FIFO or free-running delay line,
// with occupancy, level flags and sticky error flags.
module bram_fifo_cfg
    import bram_fifo_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int MAX_DEPTH  = ACC_MAX_DEPTH,
    parameter int AF_MARGIN  = 4,
    parameter int AW         = clogb2(MAX_DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [AW:0]           cfg_depth,
    input  logic                  cfg_mode,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  dout_valid,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  cfg_err
);

    localparam logic [AW:0]   MAX_D  = (AW + 1)'(MAX_DEPTH);
    localparam logic [AW+1:0] MARGIN = (AW + 2)'(AF_MARGIN);

    logic [AW:0]   depth_reg;
    logic          mode_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full_reg, empty_reg, af_reg;
    logic          overflow_reg, underflow_reg, cfg_err_reg, dout_valid_reg;

    logic          is_fifo, active, rd_acc, wr_acc, depth_ok, af_next;
    logic [AW:0]   count_next;
    logic [AW-1:0] wr_ptr_next, rd_ptr_next;

    function automatic logic [AW-1:0] ptr_advance(input logic [AW-1:0] ptr,
                                                  input logic [AW:0]   depth);
        if ({1'b0, ptr} == depth - (AW + 1)'(1))
            return '0;
        return ptr + AW'(1);
    endfunction

    always_comb begin
        is_fifo     = (mode_reg == MODE_FIFO);
        active      = rst & ~clear;
        rd_acc      = active & rden & (~is_fifo | ~empty_reg);
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_acc      = active & wren & (~is_fifo | ~full_reg | rd_acc);
        count_next  = count_reg + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        af_next     = ({1'b0, count_next} + MARGIN) >= {1'b0, depth_reg};
        depth_ok    = (cfg_depth >= (AW + 1)'(2)) && (cfg_depth <= MAX_D);
        wr_ptr_next = ptr_advance(wr_ptr_reg, depth_reg);
        rd_ptr_next = ptr_advance(rd_ptr_reg, depth_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            af_reg         <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            dout_valid_reg <= 1'b0;
            if (!rst) begin
                depth_reg   <= MAX_D;
                mode_reg    <= MODE_FIFO;
                cfg_err_reg <= 1'b0;
                empty_reg   <= 1'b1;
            end else begin
                depth_reg   <= depth_ok ? cfg_depth : MAX_D;
                mode_reg    <= cfg_mode;
                cfg_err_reg <= ~depth_ok;
                empty_reg   <= (cfg_mode == MODE_FIFO);
            end
        end else begin
            if (wr_acc)
                wr_ptr_reg <= wr_ptr_next;
            if (rd_acc)
                rd_ptr_reg <= rd_ptr_next;
            dout_valid_reg <= rd_acc;
            // Level and error flags stay at zero in delay mode.
            if (is_fifo) begin
                count_reg     <= count_next;
                full_reg      <= (count_next == depth_reg);
                empty_reg     <= (count_next == '0);
                af_reg        <= af_next;
                overflow_reg  <= overflow_reg | (wren & ~wr_acc);
                underflow_reg <= underflow_reg | (rden & ~rd_acc);
            end
        end
    end

    BRAM_singlePort_readFirst #(
        .RAM_WIDTH      (DATA_WIDTH),
        .RAM_DEPTH      (MAX_DEPTH),
        .AW             (AW),
        .RAM_PERFORMANCE("LOW_LATENCY")
    ) u_bram (
        .clk   (clk),
        .addra (wr_ptr_reg),
        .addrb (rd_ptr_reg),
        .dina  (DI),
        .ena   (wr_acc),
        .wea   (wr_acc),
        .enb   (rd_acc),
        .rstb  (~rst | clear),
        .regceb(1'b1),
        .doutb (DO)
    );

    assign dout_valid  = dout_valid_reg;
    assign count       = count_reg;
    assign full        = full_reg;
    assign empty       = empty_reg;
    assign almost_full = af_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign cfg_err     = cfg_err_reg;

endmodule
